uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  UART transmit engine (8N1, LSB first). It is the downstream consumer of the UART CSR block:
//  - takes U_TX_DATA.DATA and the one-cycle U_TX_CTRL.TX_START pulse;
//  - drives the serial tx pin;
//  - returns U_TX_STAT.READY and U_TX_STAT.TX_DONE.
//  It sits between the CSR block and the top-level UART pad.
// PARAMETERS
//  CLKS_PER_BIT  868  clock cycles per serial bit (100 MHz / 115200); legal range >= 2
//  DATA_BITS     8    payload bits per frame; fixed at 8 for this design
// PORTS
//  clk        in   1  system clock; single clock domain
//  rst_n      in   1  asynchronous, active-low reset
//  tx_data    in   8  byte to send; sampled only on an accepted tx_start
//  tx_start   in   1  start request, one-cycle pulse from the CSR block
//  tx_ready   out  1  engine idle, can accept tx_start; feeds csr_u_tx_stat_ready_in
//  tx_done    out  1  sticky "last frame finished"; feeds csr_u_tx_stat_tx_done_in
//  tx         out  1  serial line, idle high
// BEHAVIOUR
//  Reset (async assert, sync release), values while rst_n=0:
//   tx=1, tx_ready=1, tx_done=0, state=IDLE, all counters 0.
//   Reset mid-frame aborts the frame; tx returns high with no glitch low.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE : tx=1, tx_ready=1.
//     tx_start=1 -> latch tx_data into shift reg, clear tx_done, go START.
//   START: tx=0 for CLKS_PER_BIT cycles, then go DATA with bit_idx=0.
//   DATA : tx=shift[0] for CLKS_PER_BIT cycles per bit.
//     At each bit end: shift right, bit_idx++.
//     After bit_idx=7 ends, go STOP.
//   STOP : tx=1 for CLKS_PER_BIT cycles.
//     At the end: set tx_done=1, go IDLE.
//  Outputs are registered and decoded from state:
//   - tx_ready is 0 in START, DATA and STOP;
//   - tx falls on the first clk edge after the cycle tx_start is accepted (latency 1).
//  Frame length is exactly 10*CLKS_PER_BIT cycles, from the tx falling edge to tx_ready rising.
//  tx_start with tx_ready=0 is ignored: the frame in flight is unaffected, and no queueing.
//   This includes tx_start in the final STOP cycle.
//  Back-to-back frames:
//   - tx_ready is high for at least one IDLE cycle between frames;
//   - tx_start in that cycle is accepted;
//   - the stop bit is never shortened.
//  tx_done:
//   - rises together with tx_ready at the end of STOP;
//   - stays high until the next accepted tx_start, and clears in the same edge that enters START;
//   - is held as a level so the CSR clear-on-read sampling cannot miss it.
//  tx_data changing while busy has no effect; the shift register holds the latched copy.
//  Baud counter:
//   - width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1;
//   - the bit end is the cycle with count == CLKS_PER_BIT-1;
//   - wraps to 0 on every state change and is held at 0 in IDLE.
//  bit_idx is 3 bits; no wrap beyond 7 is ever used.
//  CLKS_PER_BIT < 2 is rejected at elaboration (generate-time error).
// STRUCTURE
//  Shared include uart_defs.vh holds:
//   - localparams for FSM encodings: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
//   - UART_DATA_BITS=8;
//   - the default CLKS_PER_BIT.
//   The future uart_rx_engine reuses it.
//  One sub-module: uart_baud_gen.
//   - parameter CLKS_PER_BIT;
//   - ports clk, rst_n, clr, tick;
//   - free-running bit-period counter, cleared by clr, with a one-cycle tick at the bit end.
//  Top-level wiring:
//   - tx_ready -> csr_u_tx_stat_ready_in
//   - tx_done  -> csr_u_tx_stat_tx_done_in
//   - csr_u_tx_data_data_out -> tx_data
//   - csr_u_tx_ctrl_tx_start_out -> tx_start
// TESTING  (CLKS_PER_BIT=4 unless noted)
//  1. Reset: rst_n=0 mid-DATA -> tx=1, tx_ready=1, tx_done=0 immediately;
//     after release, stays idle until tx_start.
//  2. Single frame: tx_data=8'hA5, tx_start pulse -> tx=0 on the next edge.
//     Line bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; tx_ready low for 40 cycles; then tx_done=1.
//  3. Busy ignore: tx_start with tx_data=8'hFF during frame 8'h00 -> line shows 8'h00 only.
//     tx_done is not cleared early; no second frame follows.
//  4. Back-to-back: tx_start on the first tx_ready=1 cycle with 8'h3C -> second frame starts next edge.
//     tx_done is high for exactly that one cycle, and the stop bit is a full 4 cycles.
//  5. Sticky done: after a frame, idle for 100 cycles -> tx_done stays 1;
//     a new tx_start clears it on the START edge.
//  6. Baud scaling: CLKS_PER_BIT=868, tx_data=8'h55 -> every bit is exactly 868 cycles.
//     The frame is 8680 cycles (checked by a line monitor).

Source files
------------

// File: rtl/uart_tx_engine_pkg.sv
`default_nettype none
// ============================================================================
// uart_tx_engine_pkg : shared UART constants, FSM encoding and line decode
// Rev 1.0
// ============================================================================
package uart_tx_engine_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Serial line level for a given state; data_bit is only used in ST_DATA.
  function automatic logic tx_line_level(input tx_state_e st, input logic data_bit);
    logic lvl;
    case (st)
      ST_START: lvl = 1'b0;
      ST_DATA:  lvl = data_bit;
      default:  lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_engine_if.sv
`default_nettype none
// ============================================================================
// uart_tx_engine_if : CSR <-> TX engine handshake (data, start, ready, done)
// Rev 1.0
// ============================================================================
interface uart_tx_engine_if;
  import uart_tx_engine_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_start;
  logic                      tx_ready;
  logic                      tx_done;

  // master = CSR block, slave = transmit engine
  modport master (
    output tx_data,
    output tx_start,
    input  tx_ready,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_ready,
    output tx_done
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_engine_baud_gen.sv
`default_nettype none
// ============================================================================
// uart_baud_gen : bit-period counter with a one-cycle tick at the bit end
// Rev 1.0
// ============================================================================
module uart_baud_gen
  import uart_tx_engine_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int             CNT_W    = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick is decoded from the registered count only, so the FSM may use it
  // to build clr_i without forming a combinational loop.
  assign tick_o = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// uart_tx_engine : 8N1 LSB-first UART transmitter fed by the UART CSR block
// Rev 1.0
// ============================================================================
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_engine_if.slave   csr,
  output logic              tx_o
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_engine: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS != 8) begin : g_bad_data_bits
      $error("uart_tx_engine: DATA_BITS is fixed at 8");
    end
  endgenerate

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 w_baud_clr;
  logic                 w_baud_tick;

  // Counter sits at zero in IDLE and restarts on every state change, so
  // each bit period begins exactly on the edge that enters its state.
  assign w_baud_clr = (state_q == ST_IDLE) || (state_d != state_q);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (w_baud_clr),
    .tick_o (w_baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    done_d    = done_q;

    case (state_q)
      ST_IDLE: begin
        if (csr.tx_start) begin
          shift_d   = csr.tx_data;
          bit_idx_d = '0;
          done_d    = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (w_baud_tick) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_baud_tick) begin
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_baud_tick) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, giving a
    // one-edge latency from an accepted tx_start to the falling start bit.
    tx_d    = tx_line_level(state_d, shift_d[0]);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign tx_o         = tx_q;
  assign csr.tx_ready = ready_q;
  assign csr.tx_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_engine : directed + randomized checks of the UART TX engine
// Rev 1.0
// ============================================================================
module tb_uart_tx_engine;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_engine_if bus4 ();
  uart_tx_engine_if bus868 ();
  logic tx4;
  logic tx868;

  uart_tx_engine #(.CLKS_PER_BIT(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .csr   (bus4),
    .tx_o  (tx4)
  );

  uart_tx_engine #(.CLKS_PER_BIT(868)) dut868 (
    .clk   (clk),
    .rst_n (rst_n),
    .csr   (bus868),
    .tx_o  (tx868)
  );

  int checks = 0;
  int errors = 0;
  bit sel868 = 1'b0;

  function automatic logic obs_tx();    return sel868 ? tx868 : tx4;                   endfunction
  function automatic logic obs_ready(); return sel868 ? bus868.tx_ready : bus4.tx_ready; endfunction
  function automatic logic obs_done();  return sel868 ? bus868.tx_done : bus4.tx_done;   endfunction

  // Expected line level k cycles after the start-bit falling edge of a frame.
  function automatic logic exp_line(input logic [7:0] d, input int cpb, input int k);
    int b;
    b = k / cpb;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] d);
    if (sel868) begin
      bus868.tx_start = s;
      bus868.tx_data  = d;
    end else begin
      bus4.tx_start = s;
      bus4.tx_data  = d;
    end
  endtask

  task automatic idle_cycles(input int n, input logic exp_done);
    for (int i = 0; i < n; i++) begin
      check($sformatf("idle_tx i=%0d", i), obs_tx(), 1);
      check($sformatf("idle_ready i=%0d", i), obs_ready(), 1);
      check($sformatf("idle_done i=%0d", i), obs_done(), exp_done);
      @(negedge clk);
    end
  endtask

  // Called at a negedge with the engine idle. Sends d, optionally pulsing a
  // stray tx_start carrying busy_d during cycle inject_at of the frame, and
  // scrambles tx_data every busy cycle.
  task automatic frame(input logic [7:0] d, input int inject_at, input logic [7:0] busy_d);
    int cpb;
    cpb = sel868 ? 868 : 4;
    check("pre_ready", obs_ready(), 1);
    drive(1'b1, d);
    @(negedge clk);
    for (int k = 0; k < 10 * cpb; k++) begin
      if (k == inject_at) drive(1'b1, busy_d);
      else                drive(1'b0, 8'($urandom));
      check($sformatf("tx d=%0h k=%0d", d, k), obs_tx(), exp_line(d, cpb, k));
      check($sformatf("busy_ready k=%0d", k), obs_ready(), 0);
      check($sformatf("busy_done k=%0d", k), obs_done(), 0);
      @(negedge clk);
    end
    drive(1'b0, 8'($urandom));
    check("end_ready", obs_ready(), 1);
    check("end_done", obs_done(), 1);
    check("end_tx", obs_tx(), 1);
  endtask

  initial begin
    logic [7:0] rd;
    int         inj;

    bus4.tx_start   = 1'b0;
    bus4.tx_data    = 8'h00;
    bus868.tx_start = 1'b0;
    bus868.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", tx4, 1);
    check("rst_ready", bus4.tx_ready, 1);
    check("rst_done", bus4.tx_done, 0);
    check("rst_tx868", tx868, 1);
    rst_n = 1'b1;
    @(negedge clk);
    idle_cycles(5, 1'b0);

    // Single frame, then sticky done and clear on the next START edge
    frame(8'hA5, -1, 8'h00);
    @(negedge clk);
    idle_cycles(100, 1'b1);
    frame(8'($urandom), -1, 8'h00);
    @(negedge clk);

    // Stray tx_start mid-frame and in the final STOP cycle
    frame(8'h00, 13, 8'hFF);
    @(negedge clk);
    idle_cycles(5, 1'b1);
    frame(8'h00, 39, 8'hFF);
    @(negedge clk);
    idle_cycles(5, 1'b1);

    // Back-to-back: second start lands in the single IDLE cycle
    frame(8'h96, -1, 8'h00);
    frame(8'h3C, -1, 8'h00);
    @(negedge clk);
    idle_cycles(3, 1'b1);

    for (int r = 0; r < 6; r++) begin
      rd  = 8'($urandom);
      inj = int'($urandom_range(0, 45));
      frame(rd, inj, 8'($urandom));
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 5)), 1'b1);
    end

    // Asynchronous reset in the middle of the data bits
    drive(1'b1, 8'h00);
    @(negedge clk);
    drive(1'b0, 8'h00);
    repeat (14) @(negedge clk);
    check("mid_data_tx", tx4, 0);
    check("mid_data_ready", bus4.tx_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx4, 1);
    check("async_rst_ready", bus4.tx_ready, 1);
    check("async_rst_done", bus4.tx_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(10, 1'b0);
    frame(8'h5A, -1, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_clears_done", bus4.tx_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3, 1'b0);

    // Full-rate baud: the other instance must have stayed idle until now
    sel868 = 1'b1;
    idle_cycles(2, 1'b0);
    frame(8'h55, -1, 8'h00);
    @(negedge clk);
    idle_cycles(3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
